fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/rv32i_types.sv | 11 +
 rtl/fq_ptr.sv | 23 ++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types used by the fetch queue and downstream decode.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrap-bit FIFO pointer: index bits plus one extra bit that toggles on each lap.
module fq_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH):0]   ptr
);

    // DEPTH is a power of two, so natural overflow of the extra bit is the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch-to-decode instruction queue with flush.
// Optional same-cycle empty-queue bypass enabled by macro FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  rv32i_word                enq_pc,
    input  rv32i_word                enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output rv32i_word                deq_pc,
    output rv32i_word                deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [AW:0]      head;
    logic [AW:0]      tail;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    fetch_entry_t     head_entry;

    assign empty      = (head == tail);
    assign full       = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign enq_ready  = !full;
    assign count      = tail - head;
    assign head_entry = mem[head[AW-1:0]];

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // An empty queue forwards the incoming entry straight to decode; if decode
    // takes it, it never touches storage.
    always_comb begin
        bypass    = empty && enq_valid && !flush;
        deq_valid = (!empty && !flush) || bypass;
        deq_pc    = head_entry.pc;
        deq_instr = head_entry.instr;
        if (bypass) begin
            deq_pc    = enq_pc;
            deq_instr = enq_instr;
        end
        enq_fire  = enq_valid && enq_ready && !flush && !(bypass && deq_ready);
        deq_fire  = deq_valid && deq_ready && !flush && !empty;
    end
`else
    always_comb begin
        deq_valid = !empty && !flush;
        deq_pc    = head_entry.pc;
        deq_instr = head_entry.instr;
        enq_fire  = enq_valid && enq_ready && !flush;
        deq_fire  = deq_valid && deq_ready;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire) begin
            mem[tail[AW-1:0]] <= '{pc: enq_pc, instr: enq_instr};
        end
    end

    fq_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (deq_fire),
        .ptr   (head)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (enq_fire),
        .ptr   (tail)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); bypass expectations
// follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  count;

    int pass_count;
    int total_count;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_count++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            pass_count++;
        end
    endtask

    // Inputs change 1ns after the rising edge, then settle before any check.
    task automatic applyStimulus(input logic fl, input logic ev, input logic [31:0] pc,
                                 input logic [31:0] instr, input logic dr);
        flush     = fl;
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = instr;
        deq_ready = dr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_count  = 0;
        total_count = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        checkOutput("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
        checkOutput("rst_count", {29'b0, count}, 32'd0);
        checkOutput("rst_deq_pc", deq_pc, 32'h0);
        checkOutput("rst_deq_instr", deq_instr, 32'h0);

        // Single entry appears one cycle after enqueue
        applyStimulus(1'b0, 1'b1, 32'h60, 32'h00000013, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("lat_deq_valid", {31'b0, deq_valid}, 32'd1);
        checkOutput("lat_deq_pc", deq_pc, 32'h60);
        checkOutput("lat_deq_instr", deq_instr, 32'h00000013);
        checkOutput("lat_count", {29'b0, count}, 32'd1);

        // Fill to DEPTH, then a fifth offer must be ignored
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h60 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("full_count", {29'b0, count}, 32'd4);
        checkOutput("full_enq_ready", {31'b0, enq_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h70, 32'hdead, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("full_ignore_count", {29'b0, count}, 32'd4);
        checkOutput("full_head_pc", deq_pc, 32'h60);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            checkOutput("drain_valid", {31'b0, deq_valid}, 32'd1);
            checkOutput("drain_pc", deq_pc, 32'h60 + 32'(4 * i));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("drain_count", {29'b0, count}, 32'd0);
        checkOutput("drain_deq_valid", {31'b0, deq_valid}, 32'd0);

        // Steady-state streaming at count=2 across pointer wrap
        applyStimulus(1'b0, 1'b1, 32'h100, 32'h2100, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h104, 32'h2104, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h108 + 32'(4 * i), 32'h2108 + 32'(4 * i), 1'b1);
            checkOutput("stream_count", {29'b0, count}, 32'd2);
            checkOutput("stream_pc", deq_pc, 32'h100 + 32'(4 * i));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("stream_end_count", {29'b0, count}, 32'd2);
        checkOutput("stream_end_pc", deq_pc, 32'h128);
        checkOutput("stream_end_instr", deq_instr, 32'h2128);

        // Flush at count=3 discards everything including the same-cycle enqueue
        applyStimulus(1'b0, 1'b1, 32'h130, 32'h2130, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("preflush_count", {29'b0, count}, 32'd3);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h3200, 1'b1);
        checkOutput("flush_deq_valid", {31'b0, deq_valid}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("postflush_count", {29'b0, count}, 32'd0);
        checkOutput("postflush_deq_valid", {31'b0, deq_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h300, 32'h3300, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("postflush_new_pc", deq_pc, 32'h300);
        checkOutput("postflush_new_count", {29'b0, count}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        // Empty queue with enqueue and dequeue offered together
        applyStimulus(1'b0, 1'b1, 32'h80, 32'h4080, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput("byp_deq_valid", {31'b0, deq_valid}, 32'd1);
        checkOutput("byp_deq_pc", deq_pc, 32'h80);
        checkOutput("byp_deq_instr", deq_instr, 32'h4080);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("byp_count", {29'b0, count}, 32'd0);
`else
        checkOutput("nobyp_deq_valid", {31'b0, deq_valid}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("nobyp_count", {29'b0, count}, 32'd1);
        checkOutput("nobyp_deq_pc", deq_pc, 32'h80);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
`endif

        // Reset mid-stream at count=3 overrides concurrent handshakes
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h400 + 32'(4 * i), 32'h5400 + 32'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("prerst_count", {29'b0, count}, 32'd3);
        checkOutput("prerst_pc", deq_pc, 32'h400);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h500, 32'h5500, 1'b1);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("midrst_count", {29'b0, count}, 32'd0);
        checkOutput("midrst_deq_valid", {31'b0, deq_valid}, 32'd0);
        checkOutput("midrst_enq_ready", {31'b0, enq_ready}, 32'd1);
        checkOutput("midrst_deq_pc", deq_pc, 32'h0);
        checkOutput("midrst_deq_instr", deq_instr, 32'h0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
